// File: rtl/stack_op_issuer_if.sv
// Instruction handshake between the decoder (master) and the stack
// operation issuer (slave).
//
// Handshake: the master raises instr_valid with opcode/imm stable and keeps
// them unchanged until a cycle where instr_ready is also high. That cycle is
// the transfer. The slave samples nothing while instr_ready is low.
interface stack_op_issuer_if #(
  parameter int DBITS = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [3:0]       opcode;
  logic [DBITS-1:0] imm;

  modport master (
    output instr_valid,
    output opcode,
    output imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  opcode,
    input  imm,
    output instr_ready
  );
endinterface

// File: rtl/stack_op_issuer.sv
// Stack operation issuer: accepts decoded stack instructions and drives the
// operand stack's pop/pop-second/push strobes. Single-cycle ops finish in the
// accept cycle. DUP and SWAP need extra push cycles because the stack file
// takes at most one push per cycle. Depth is tracked here so that underflow
// and overflow are caught before any strobe is issued.
module stack_op_issuer #(
  parameter int DBITS = 32,
  parameter int DEPTH = 256,
  parameter int CBITS = 9
) (
  input  logic             clk,
  input  logic             rst,
  stack_op_issuer_if.slave ins,
  output logic             st_en1,
  output logic             st_en2,
  output logic             st_we,
  output logic [DBITS-1:0] st_din,
  input  logic [DBITS-1:0] st_dout1,
  input  logic [DBITS-1:0] st_dout2,
  output logic [DBITS-1:0] result,
  output logic             result_valid,
  output logic [CBITS-1:0] depth,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Opcode map
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_DUP  = 4'd9;
  localparam logic [3:0] OP_SWAP = 4'd10;

  // Sequencer states
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_DUP_PUSH  = 2'd1;
  localparam logic [1:0] S_SW_PUSH_A = 2'd2;
  localparam logic [1:0] S_SW_PUSH_B = 2'd3;

  localparam logic [CBITS-1:0] DEPTH_C = CBITS'(DEPTH);
  localparam logic [CBITS-1:0] ONE_C   = CBITS'(1);
  localparam logic [CBITS-1:0] TWO_C   = CBITS'(2);

  logic [1:0]       state;
  logic [DBITS-1:0] tmp_a;
  logic [DBITS-1:0] tmp_b;

  // Decode results for the instruction currently on the handshake
  logic             legal;
  logic [1:0]       need;
  logic             is_alu;
  logic             underflow;
  logic             overflow;
  logic             guard;
  logic             accept;
  logic             fire;
  logic             reject;
  logic [DBITS-1:0] alu_res;

  assign dbg_state       = state;
  assign ins.instr_ready = (state == S_IDLE);
  assign accept          = ins.instr_valid && ins.instr_ready;

  // Operand requirement and legality of the presented opcode
  always_comb begin
    legal  = 1'b1;
    need   = 2'd0;
    is_alu = 1'b0;
    case (ins.opcode)
      OP_NOP, OP_PUSH: need = 2'd0;
      OP_POP, OP_NOT, OP_DUP: need = 2'd1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        need   = 2'd2;
        is_alu = 1'b1;
      end
      OP_SWAP: need = 2'd2;
      default: legal = 1'b0;
    endcase
  end

  // Guards: a guarded instruction is consumed but produces no strobes
  always_comb begin
    underflow = (depth < CBITS'(need));
    overflow  = ((ins.opcode == OP_PUSH) || (ins.opcode == OP_DUP)) &&
                (depth == DEPTH_C);
    guard     = !legal || underflow || overflow;
    fire      = accept && !guard;
    reject    = accept && guard;
  end

  // Binary ALU: second entry is the left operand, top of stack the right
  always_comb begin
    alu_res = '0;
    case (ins.opcode)
      OP_ADD:  alu_res = st_dout2 + st_dout1;
      OP_SUB:  alu_res = st_dout2 - st_dout1;
      OP_AND:  alu_res = st_dout2 & st_dout1;
      OP_OR:   alu_res = st_dout2 | st_dout1;
      OP_XOR:  alu_res = st_dout2 ^ st_dout1;
      default: alu_res = '0;
    endcase
  end

  // Stack strobes: accept-cycle op in IDLE, fixed pushes in sequencing states
  always_comb begin
    st_en1 = 1'b0;
    st_en2 = 1'b0;
    st_we  = 1'b0;
    st_din = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            if (is_alu) begin
              st_en1 = 1'b1;
              st_en2 = 1'b1;
              st_we  = 1'b1;
              st_din = alu_res;
            end else begin
              case (ins.opcode)
                OP_PUSH: begin
                  st_we  = 1'b1;
                  st_din = ins.imm;
                end
                OP_POP: st_en1 = 1'b1;
                OP_NOT: begin
                  st_en1 = 1'b1;
                  st_we  = 1'b1;
                  st_din = ~st_dout1;
                end
                OP_DUP: begin
                  // Top is popped and rewritten in place; the copy follows.
                  st_en1 = 1'b1;
                  st_we  = 1'b1;
                  st_din = st_dout1;
                end
                OP_SWAP: begin
                  st_en1 = 1'b1;
                  st_en2 = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        S_DUP_PUSH, S_SW_PUSH_A: begin
          st_we  = 1'b1;
          st_din = tmp_a;
        end
        S_SW_PUSH_B: begin
          st_we  = 1'b1;
          st_din = tmp_b;
        end
        default: ;
      endcase
    end
  end

  // Sequencer state and the operands latched for the follow-up pushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tmp_a <= '0;
      tmp_b <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire && (ins.opcode == OP_DUP)) begin
            tmp_a <= st_dout1;
            state <= S_DUP_PUSH;
          end else if (fire && (ins.opcode == OP_SWAP)) begin
            tmp_a <= st_dout1;
            tmp_b <= st_dout2;
            state <= S_SW_PUSH_A;
          end
        end
        S_DUP_PUSH:  state <= S_IDLE;
        S_SW_PUSH_A: state <= S_SW_PUSH_B;
        S_SW_PUSH_B: state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // Depth counter follows the net pops/pushes issued each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fire) begin
            case (ins.opcode)
              OP_PUSH: depth <= depth + ONE_C;
              OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                depth <= depth - ONE_C;
              OP_SWAP: depth <= depth - TWO_C;
              default: ;
            endcase
          end
        end
        S_DUP_PUSH, S_SW_PUSH_A, S_SW_PUSH_B: depth <= depth + ONE_C;
        default: ;
      endcase
    end
  end

  // Popped value, its valid pulse, and the error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      result_valid <= fire && (ins.opcode == OP_POP);
      err          <= reject;
      if (fire && (ins.opcode == OP_POP)) begin
        result <= st_dout1;
      end
    end
  end

endmodule

// File: tb/tb_stack_op_issuer.sv
// Bench for stack_op_issuer: a simple stack register file responds to the
// strobes, and a queue-based stack model predicts strobes, results, errors
// and depth for each instruction.
module tb_stack_op_issuer;
  localparam int DBITS = 32;
  localparam int DEPTH = 256;
  localparam int CBITS = 9;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_op_issuer_if #(.DBITS(DBITS)) ins ();

  logic             st_en1, st_en2, st_we;
  logic [DBITS-1:0] st_din, st_dout1, st_dout2, result;
  logic             result_valid, err;
  logic [CBITS-1:0] depth;
  logic [1:0]       dbg_state;

  stack_op_issuer #(.DBITS(DBITS), .DEPTH(DEPTH), .CBITS(CBITS)) dut (
    .clk(clk),
    .rst(rst),
    .ins(ins),
    .st_en1(st_en1),
    .st_en2(st_en2),
    .st_we(st_we),
    .st_din(st_din),
    .st_dout1(st_dout1),
    .st_dout2(st_dout2),
    .result(result),
    .result_valid(result_valid),
    .depth(depth),
    .err(err),
    .dbg_state(dbg_state)
  );

  // Stack register file: pops first, then an optional push
  logic [DBITS-1:0] mem [0:DEPTH];
  int sp;
  int sp_pop;

  always_comb begin
    sp_pop = sp - (st_en1 ? 1 : 0) - (st_en2 ? 1 : 0);
  end

  always_comb begin
    st_dout1 = '0;
    st_dout2 = '0;
    if (sp >= 1) st_dout1 = mem[sp-1];
    if (sp >= 2) st_dout2 = mem[sp-2];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0;
    end else begin
      if (st_we && sp_pop >= 0 && sp_pop <= DEPTH) mem[sp_pop] <= st_din;
      sp <= sp_pop + (st_we ? 1 : 0);
    end
  end

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [DBITS-1:0] ref_q[$];
  logic [DBITS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: issue one instruction and check every cycle it occupies
  task automatic issue(input logic [3:0] op, input logic [DBITS-1:0] im);
    int sz;
    int need;
    bit guard;
    bit has_res;
    logic e1, e2, we;
    logic [DBITS-1:0] din, a, b, r;
    int base;
    sz      = ref_q.size();
    need    = 0;
    has_res = 0;
    e1 = 0; e2 = 0; we = 0;
    din = '0; a = '0; b = '0; r = '0;
    exp_q.delete();
    if (op == 4'd2 || op == 4'd8 || op == 4'd9) need = 1;
    if ((op >= 4'd3 && op <= 4'd7) || op == 4'd10) need = 2;
    guard = (op > 4'd10) || (sz < need) || ((op == 4'd1 || op == 4'd9) && sz == DEPTH);
    if (!guard) begin
      case (op)
        4'd1: begin we = 1; din = im; ref_q.push_back(im); end
        4'd2: begin e1 = 1; has_res = 1; r = ref_q.pop_back(); end
        4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
          e1 = 1; e2 = 1; we = 1;
          a = ref_q.pop_back();
          b = ref_q.pop_back();
          case (op)
            4'd3:    din = b + a;
            4'd4:    din = b - a;
            4'd5:    din = b & a;
            4'd6:    din = b | a;
            default: din = b ^ a;
          endcase
          ref_q.push_back(din);
        end
        4'd8: begin
          e1 = 1; we = 1;
          a = ref_q.pop_back();
          din = ~a;
          ref_q.push_back(din);
        end
        4'd9: begin
          e1 = 1; we = 1;
          a = ref_q[$];
          din = a;
          exp_q.push_back(a);
          ref_q.push_back(a);
        end
        4'd10: begin
          e1 = 1; e2 = 1;
          a = ref_q.pop_back();
          b = ref_q.pop_back();
          exp_q.push_back(a);
          exp_q.push_back(b);
          ref_q.push_back(a);
          ref_q.push_back(b);
        end
        default: ;
      endcase
    end
    @(negedge clk);
    check("rv_quiet", result_valid, 0);
    check("err_quiet", err, 0);
    check("ready_idle", ins.instr_ready, 1);
    ins.instr_valid = 1'b1;
    ins.opcode      = op;
    ins.imm         = im;
    #1;
    check("acc_en1", st_en1, e1);
    check("acc_en2", st_en2, e2);
    check("acc_we", st_we, we);
    if (we) check("acc_din", st_din, din);
    @(posedge clk);
    #1;
    ins.instr_valid = 1'b0;
    ins.opcode      = 4'($urandom);
    ins.imm         = $urandom;
    @(negedge clk);
    check("result_valid", result_valid, has_res);
    if (has_res) check("result", result, r);
    check("err", err, guard);
    base = ref_q.size() - exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      check("seq_ready", ins.instr_ready, 0);
      check("seq_en1", st_en1, 0);
      check("seq_en2", st_en2, 0);
      check("seq_we", st_we, 1);
      check("seq_din", st_din, exp_q[i]);
      check("seq_depth", depth, base + i);
      // A waiting producer must not be sampled while ready is low.
      ins.instr_valid = 1'b1;
      ins.opcode      = 4'd1;
      ins.imm         = $urandom;
      @(posedge clk);
      #1;
      ins.instr_valid = 1'b0;
      @(negedge clk);
    end
    check("depth", depth, ref_q.size());
    check("ready_after", ins.instr_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_depth"}, depth, 0);
    check({tag, "_ready"}, ins.instr_ready, 1);
    check({tag, "_strobes"}, {st_en1, st_en2, st_we}, 3'b000);
    check({tag, "_din"}, st_din, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ins.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
    ref_q.delete();
  endtask

  initial begin
    int r;
    ins.instr_valid = 1'b0;
    ins.opcode      = 4'd0;
    ins.imm         = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    check("por_result", result, 0);
    rst = 1'b0;

    // PUSH 5, PUSH 3, ADD, POP
    issue(4'd1, 32'd5);
    issue(4'd1, 32'd3);
    issue(4'd3, 32'd0);
    issue(4'd2, 32'd0);
    check("add_result", result, 32'd8);

    // SUB, including the wrapping case
    issue(4'd1, 32'h10);
    issue(4'd1, 32'h3);
    issue(4'd4, 32'd0);
    issue(4'd2, 32'd0);
    check("sub_result", result, 32'hD);
    issue(4'd1, 32'd1);
    issue(4'd1, 32'd2);
    issue(4'd4, 32'd0);
    issue(4'd2, 32'd0);
    check("sub_wrap", result, 32'hFFFF_FFFF);

    // DUP
    issue(4'd1, 32'd7);
    issue(4'd9, 32'd0);
    issue(4'd2, 32'd0);
    check("dup_pop1", result, 32'd7);
    issue(4'd2, 32'd0);
    check("dup_pop2", result, 32'd7);

    // SWAP
    issue(4'd1, 32'd1);
    issue(4'd1, 32'd2);
    issue(4'd10, 32'd0);
    issue(4'd2, 32'd0);
    check("swap_pop1", result, 32'd1);
    issue(4'd2, 32'd0);
    check("swap_pop2", result, 32'd2);

    // Underflow and illegal opcode guards
    issue(4'd2, 32'd0);
    issue(4'd1, 32'd4);
    issue(4'd3, 32'd0);
    issue(4'd10, 32'd0);
    issue(4'd12, 32'd0);
    issue(4'd15, 32'd0);
    issue(4'd2, 32'd0);
    issue(4'd8, 32'd0);
    issue(4'd9, 32'd0);

    // Fill to capacity, then overflow on PUSH and DUP
    for (int i = 0; i < DEPTH; i++) issue(4'd1, 32'(i * 3 + 1));
    check("full_depth", depth, DEPTH);
    issue(4'd1, 32'hDEAD);
    issue(4'd9, 32'd0);
    issue(4'd2, 32'd0);
    check("full_pop", result, 32'(3 * (DEPTH - 1) + 1));
    do_reset();

    // Reset in the middle of a SWAP
    issue(4'd1, 32'd1);
    issue(4'd1, 32'd2);
    @(negedge clk);
    ins.instr_valid = 1'b1;
    ins.opcode      = 4'd10;
    #1;
    check("sw_acc", {st_en1, st_en2, st_we}, 3'b110);
    @(posedge clk);
    #1;
    ins.instr_valid = 1'b0;
    @(negedge clk);
    check("sw_push_a_din", st_din, 32'd2);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    ref_q.delete();
    #1;
    check_reset_outputs("post_rst");
    issue(4'd1, 32'd9);
    issue(4'd2, 32'd0);
    check("post_rst_pop", result, 32'd9);

    // Randomised instruction mix against the stack model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 6)       issue(4'd1, $urandom);
      else if (r < 18) issue(4'($urandom_range(0, 10)), $urandom);
      else             issue(4'($urandom_range(11, 15)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_op_issuer.md
Name: stack_op_issuer

Overview:
- Initiator side of the operand-stack interface; drives the stack register file's pop/pop-second/push strobes and write data.
- Accepts decoded stack instructions over a valid/ready handshake and sequences single- and multi-cycle operations (PUSH, POP, ALU, DUP, SWAP).
- Computes ALU results from the stack's two read ports and tracks stack depth to block overflow and underflow.
- Sits between the instruction decoder and the stack register file in the single-cycle stack CPU.

Parameters:
DBITS, 32, data word width; matches stack file width
DEPTH, 256, stack capacity in words; legal depth range 0..DEPTH
CBITS, 9, depth counter width; must satisfy 2^CBITS > DEPTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  decoder presents an instruction
instr_ready  out  1  issuer accepts instruction this cycle
opcode  in  4  operation code
imm  in  DBITS  immediate operand for PUSH
st_en1  out  1  pop top of stack
st_en2  out  1  pop second entry
st_we  out  1  push st_din
st_din  out  DBITS  push data
st_dout1  in  DBITS  top of stack, combinational, push-bypassed
st_dout2  in  DBITS  second entry, combinational
result  out  DBITS  popped value
result_valid  out  1  one-cycle pulse with result
depth  out  CBITS  current number of stack entries
err  out  1  one-cycle pulse: underflow, overflow or illegal opcode

Behaviour:
- Reset values: state IDLE, depth 0, tmp_a/tmp_b 0, result 0, result_valid 0, err 0. Strobes deassert during reset; st_din 0.
- Accept: an instruction is accepted when instr_valid && instr_ready. instr_ready = 1 only in IDLE.
- Strobes are combinational from state/opcode and active only in the accept cycle or in sequencing states. All strobes are 0 otherwise.
- Opcodes: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 DUP, 10 SWAP. Codes 11-15 are illegal.
- Single-cycle ops, all in the accept cycle, remaining in IDLE:
  - NOP: no strobes.
  - PUSH: st_we=1, st_din=imm; depth+1.
  - POP: st_en1=1; result<=st_dout1; result_valid pulses the next cycle; depth-1.
  - ADD/SUB/AND/OR/XOR: st_en1=st_en2=st_we=1. st_din = st_dout2 op st_dout1 (SUB = second minus top). Arithmetic is modulo 2^DBITS with no flags. depth-1.
  - NOT: st_en1=st_we=1, st_din=~st_dout1; depth unchanged.
- DUP (2 cycles):
  - Accept cycle: st_en1=st_we=1, st_din=st_dout1 (top rewritten in place), tmp_a<=st_dout1, go to DUP_PUSH.
  - DUP_PUSH: st_we=1, st_din=tmp_a, depth+1, return to IDLE.
- SWAP (3 cycles):
  - Accept cycle: st_en1=st_en2=1, tmp_a<=st_dout1, tmp_b<=st_dout2, depth-2, go to SW_PUSH_A.
  - SW_PUSH_A: st_we=1, st_din=tmp_a, depth+1, go to SW_PUSH_B.
  - SW_PUSH_B: st_we=1, st_din=tmp_b, depth+1, return to IDLE.
- Guards, checked in the accept cycle; a guarded instruction is consumed with no strobes, depth unchanged, and err pulses the next cycle:
  - Underflow: depth < required operands. POP/NOT/DUP need 1; ALU ops and SWAP need 2.
  - Overflow: PUSH or DUP when depth == DEPTH.
  - Illegal opcode.
- Depth never wraps.
- Asynchronous reset mid-sequence (DUP_PUSH or SW_*) returns immediately to IDLE with depth 0. The partially completed operation is abandoned.
- instr_valid while not ready: the instruction is held by the producer; nothing is sampled.

Test Plan:
- Reset, PUSH 5, PUSH 3, ADD, POP -> strobes 001, 001, 111 with st_din=8, then 100; result=8 with one result_valid pulse; depth 1,2,1,0.
- PUSH 0x10, PUSH 0x3, SUB, POP -> st_din=0xD on SUB; result 0xD; also check SUB with top > second wraps (1-2 = 0xFFFFFFFF).
- PUSH 7, DUP, POP, POP -> instr_ready low exactly 1 cycle after DUP accept; results 7, 7; depth 0; DUP_PUSH cycle shows st_we=1, st_din=7.
- PUSH 1, PUSH 2, SWAP, POP, POP -> ready low 2 cycles; push sequence st_din 2 then 1; POP results 1 then 2.
- Empty stack: POP, ADD with depth 1, opcode 12 -> each gives no strobes, an err pulse, depth unchanged; fill to DEPTH, then PUSH -> err, depth stays DEPTH.
- Assert rst during SW_PUSH_A -> depth 0, instr_ready 1, all strobes 0 in the next cycle; the following PUSH 9, POP returns 9.
